// File: rtl/data_sync_pkg.sv
// ---------------------------------------------------------------------------
// data_sync_pkg
// Shared constants for the data_sync clock-domain-crossing slice. The
// interface and the top level take their parameter defaults from here, so
// widths and chain depth stay consistent across the slice.
// Ports: none (package only).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package data_sync_pkg;

  // Default depth of the enable synchronizer chain. Two flops is the
  // minimum that gives a metastable first stage a full cycle to settle.
  localparam int DEFAULT_STAGES_NUM = 2;

  // Default width of the data bus crossing the domain boundary.
  localparam int DEFAULT_BUS_WIDTH = 8;

endpackage

// File: rtl/data_sync_if.sv
// ---------------------------------------------------------------------------
// data_sync_if
// Groups the crossing bus signals. The source side (master) drives the raw
// bus and its enable level; the receiving side (slave) returns the captured
// bus and the one-cycle capture strobe.
// Signals:
//   async_bus     source-domain data, held stable while async_bus_en is high
//   async_bus_en  source-domain data-valid level, asynchronous to CLK
//   sync_bus      captured data in the CLK domain
//   en_pulse      one-cycle strobe marking a fresh capture on sync_bus
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface data_sync_if
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
);

  logic [BUS_WIDTH-1:0] async_bus;
  logic                 async_bus_en;
  logic [BUS_WIDTH-1:0] sync_bus;
  logic                 en_pulse;

  // Source / stimulus side of the crossing.
  modport master (
    output async_bus,
    output async_bus_en,
    input  sync_bus,
    input  en_pulse
  );

  // Receiving side, implemented by data_sync.
  modport slave (
    input  async_bus,
    input  async_bus_en,
    output sync_bus,
    output en_pulse
  );

endinterface

// File: rtl/data_sync_bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Generic single-bit N-stage synchronizer. The input is sampled by the first
// flop and shifted through the chain; the last flop is the safe,
// CLK-domain version of d.
// Ports:
//   CLK  destination clock, rising-edge active
//   RST  synchronous active-high reset, clears the whole chain
//   d    asynchronous single-bit input
//   q    synchronized output (last stage of the chain)
// NUM_STAGES must be 2 or more.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] r_stages;

  // Shift chain: bit 0 is the only flop that sees the asynchronous input,
  // every later bit copies its predecessor so metastability has
  // NUM_STAGES-1 full cycles to resolve before reaching q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[NUM_STAGES-2:0], d};
    end
  end

  assign q = r_stages[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// ---------------------------------------------------------------------------
// data_sync
// Receiving side of a bus clock-domain crossing. Only the enable level is
// synchronized; a rising edge on the synchronized enable produces a
// one-cycle en_pulse and, in the same cycle, captures async_bus into
// sync_bus. The bus itself is never synchronized: the source guarantees it
// is stable while the enable is high, and it is sampled only at capture.
// Ports:
//   CLK  destination clock, rising-edge active
//   RST  synchronous active-high reset, clears chain, pulse and outputs
//   bus  data_sync_if slave modport (async_bus, async_bus_en in;
//        sync_bus, en_pulse out)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module data_sync
  import data_sync_pkg::*;
#(
  parameter int STAGES_NUM = DEFAULT_STAGES_NUM,
  parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH
) (
  input  logic         CLK,
  input  logic         RST,
  data_sync_if.slave   bus
);

  logic                 w_syncEn;
  logic                 w_pulse;
  logic                 r_pulseFf;
  logic                 r_enPulse;
  logic [BUS_WIDTH-1:0] r_syncBus;

  // Bring the source enable level into the CLK domain.
  bit_sync #(
    .NUM_STAGES (STAGES_NUM)
  ) u_enSync (
    .CLK (CLK),
    .RST (RST),
    .d   (bus.async_bus_en),
    .q   (w_syncEn)
  );

  // Remember the previous synchronized enable so a held-high level yields
  // only one pulse; a falling edge gives nothing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pulseFf <= 1'b0;
    end else begin
      r_pulseFf <= w_syncEn;
    end
  end

  assign w_pulse = w_syncEn & ~r_pulseFf;

  // Output stage: the strobe is registered, and the bus is captured in the
  // same edge so en_pulse and the new sync_bus value appear together.
  // Between captures sync_bus simply holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_enPulse <= 1'b0;
      r_syncBus <= '0;
    end else begin
      r_enPulse <= w_pulse;
      if (w_pulse) begin
        r_syncBus <= bus.async_bus;
      end
    end
  end

  assign bus.en_pulse = r_enPulse;
  assign bus.sync_bus = r_syncBus;

endmodule

// File: tb/tb_data_sync.sv
// ---------------------------------------------------------------------------
// tb_data_sync
// Directed testbench for data_sync with default parameters (2-stage chain,
// 8-bit bus) and a 5 ns clock. Every transfer starts right after a falling
// clock edge, so the first rising edge that samples the enable (E0) comes
// 2.5 ns later and the registered pulse is visible at the third falling edge
// after the enable is raised.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_sync;

  logic clk;
  logic rst;

  int checks;
  int errors;
  int pulseCount;
  int pulseIdx;
  logic [7:0] busLog [0:31];
  logic [7:0] fiveVals [0:4];

  data_sync_if #(.BUS_WIDTH(8)) bus ();

  data_sync #(
    .STAGES_NUM (2),
    .BUS_WIDTH  (8)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // 5 ns destination clock, first rising edge at 2.5 ns.
  initial begin
    clk = 1'b0;
    forever #2.5 clk = ~clk;
  end

  // One comparison: counts it, and on mismatch counts an error and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Watch n falling edges, logging sync_bus and counting en_pulse cycles.
  // pulseIdx is the 1-based falling edge where the first pulse was seen.
  task automatic watchEdges(input int n);
    pulseCount = 0;
    pulseIdx   = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      busLog[i] = bus.sync_bus;
      if (bus.en_pulse === 1'b1) begin
        pulseCount++;
        if (pulseIdx == 0) pulseIdx = i;
      end
    end
  endtask

  // One transfer: enable high for highNs, then low for lowNs, while the
  // output side is watched for n falling edges. Call right after a negedge.
  task automatic applyStimulus(input logic [7:0] data, input int highNs,
                               input int lowNs, input int n);
    bus.async_bus    = data;
    bus.async_bus_en = 1'b1;
    fork
      begin
        #(highNs);
        bus.async_bus_en = 1'b0;
        #(lowNs);
      end
      watchEdges(n);
    join
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fiveVals[0] = 8'h12;
    fiveVals[1] = 8'h34;
    fiveVals[2] = 8'h56;
    fiveVals[3] = 8'h78;
    fiveVals[4] = 8'h9A;

    // Reset held for two rising edges.
    rst              = 1'b1;
    bus.async_bus    = 8'h00;
    bus.async_bus_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_en_pulse", 32'(bus.en_pulse), 32'd0);
    checkOutput("reset_sync_bus", 32'(bus.sync_bus), 32'h00);
    checkOutput("reset_chain", 32'(dut.w_syncEn), 32'd0);
    rst = 1'b0;

    // Single transfer: pulse at E0+2, seen on the 3rd falling edge.
    applyStimulus(8'hA5, 17, 17, 7);
    checkOutput("single_pulse_count", 32'(pulseCount), 32'd1);
    checkOutput("single_pulse_edge", 32'(pulseIdx), 32'd3);
    checkOutput("single_bus_before", 32'(busLog[2]), 32'h00);
    checkOutput("single_bus_after", 32'(busLog[7]), 32'hA5);

    // Five back-to-back transfers.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(fiveVals[k], 17, 17, 7);
      checkOutput($sformatf("b2b%0d_pulse_count", k), 32'(pulseCount), 32'd1);
      checkOutput($sformatf("b2b%0d_pulse_edge", k), 32'(pulseIdx), 32'd3);
      checkOutput($sformatf("b2b%0d_bus", k), 32'(busLog[7]), 32'(fiveVals[k]));
    end

    // Long enable: 20 cycles high, bus changed to 0xFF after capture.
    bus.async_bus    = 8'h3C;
    bus.async_bus_en = 1'b1;
    watchEdges(4);
    checkOutput("long_pulse_count", 32'(pulseCount), 32'd1);
    checkOutput("long_pulse_edge", 32'(pulseIdx), 32'd3);
    bus.async_bus = 8'hFF;
    watchEdges(16);
    checkOutput("long_no_repulse", 32'(pulseCount), 32'd0);
    checkOutput("long_bus_held", 32'(bus.sync_bus), 32'h3C);

    // Falling edge of the enable: no pulse, no output change.
    bus.async_bus_en = 1'b0;
    watchEdges(5);
    checkOutput("fall_no_pulse", 32'(pulseCount), 32'd0);
    checkOutput("fall_bus_held", 32'(bus.sync_bus), 32'h3C);

    // Bus change with the enable low.
    bus.async_bus = 8'h55;
    watchEdges(5);
    checkOutput("idle_no_pulse", 32'(pulseCount), 32'd0);
    checkOutput("idle_bus_held", 32'(bus.sync_bus), 32'h3C);

    // Reset at edge E0+1, enable kept high through and after reset.
    bus.async_bus    = 8'h99;
    bus.async_bus_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_en_pulse", 32'(bus.en_pulse), 32'd0);
    checkOutput("midrst_sync_bus", 32'(bus.sync_bus), 32'h00);
    watchEdges(6);
    checkOutput("midrst_resync_count", 32'(pulseCount), 32'd1);
    checkOutput("midrst_resync_edge", 32'(pulseIdx), 32'd3);
    checkOutput("midrst_resync_bus", 32'(busLog[6]), 32'h99);

    // Reset on the very edge the pulse would register: reset wins.
    bus.async_bus_en = 1'b0;
    watchEdges(3);
    bus.async_bus    = 8'h42;
    bus.async_bus_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst              = 1'b0;
    bus.async_bus_en = 1'b0;
    checkOutput("samerst_en_pulse", 32'(bus.en_pulse), 32'd0);
    checkOutput("samerst_sync_bus", 32'(bus.sync_bus), 32'h00);
    watchEdges(4);
    checkOutput("samerst_no_late_pulse", 32'(pulseCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
